rv32i_data_responder: RTL and testbench
=======================================

Name: rv32i_data_responder

Overview:
Responder end of the rv32i data-memory interface: services the core's memory_read/memory_write requests with 1-clk read latency and byte-enable writes. Decodes each request into a word-addressed RAM region or a small MMIO region. The MMIO region holds a console TX FIFO (valid/ready byte stream), a free-running 64-bit cycle counter and a GPIO output register. Sits beside the processor at SoC top level, wired directly to its data-memory ports.

Parameters:
RAM_WORDS, 4096, RAM depth in 32-bit words (power of 2); RAM spans byte addresses 0 .. RAM_WORDS*4-1
MMIO_BASE, 32'h8000_0000, base byte address of the MMIO region (64-byte aligned)
FIFO_DEPTH, 16, console TX FIFO depth in bytes (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
memory_write  input  1  write request this cycle
memory_read  input  1  read request this cycle
memory_address  input  32  byte address; bits [1:0] ignored (word access)
memory_byteenable  input  4  write lane enables; bit i covers data[8i+7:8i]
memory_write_data  input  32  write data
memory_read_data  output  32  read data, valid the cycle after memory_read
console_valid  output  1  console byte available
console_data  output  8  console byte (FIFO head)
console_ready  input  1  sink accepts byte when console_valid & console_ready
gpio_out  output  32  GPIO register value
unmapped_error  output  1  sticky: any access outside RAM/MMIO map

Behaviour:
- Reset (async, active-high) clears: memory_read_data=0, console FIFO empty (console_valid=0, console_data=0), cycle counter=0, counter high shadow=0, gpio_out=0, overflow flag=0, unmapped_error=0. RAM contents not reset.
- Read: memory_read sampled at edge N -> memory_read_data updated at edge N+1 with the word selected at N; holds value until next read. Returns full word regardless of byteenable.
- Write: committed at the sampling edge; only enabled lanes change. byteenable=0 -> no effect.
- Read and write in same cycle (same address): write commits; read returns pre-write data (read-before-write).
- MMIO map (offset from MMIO_BASE):
  0x00 CONSOLE_TX: write with byteenable[0]=1 pushes data[7:0]; reads 0.
  0x04 CONSOLE_STATUS: read bit0=full, bit1=empty, bit2=overflow (sticky); writing 1 to bit2 (lane 0) clears it.
  0x08 CYCLE_LO: read returns counter[31:0] at request cycle and copies counter[63:32] into shadow in same cycle.
  0x0C CYCLE_HI: read returns shadow (coherent 64-bit read = LO then HI). Writes to 0x08/0x0C ignored.
  0x10 GPIO: R/W, byte-enable writes update gpio_out at next edge.
  Other MMIO offsets: reads 0, writes ignored, no error.
- Any address not in RAM nor the 64-byte MMIO window: reads return 0, writes ignored, unmapped_error set (sticky until reset).
- Cycle counter: +1 every clk after reset deasserts; wraps 2^64-1 -> 0.
- Console FIFO: push when full -> byte dropped, overflow set. Push and pop same cycle when full -> pop frees entry, push accepted, no overflow. Pushed byte into empty FIFO -> console_valid=1 the following cycle. console_data stable while console_valid & !console_ready.
- Status reads reflect FIFO state at the request edge (before that edge's push/pop).

Decomposition:
- rv32i_package: add MMIO offset constants (MMIO_CONSOLE_TX, MMIO_CONSOLE_STATUS, MMIO_CYCLE_LO, MMIO_CYCLE_HI, MMIO_GPIO) and an enum region_t {REGION_RAM, REGION_MMIO, REGION_NONE}.
- Sub-module rv32i_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head, registered storage, count-based full/empty).
- RAM, address decode, read mux register, counter and GPIO stay in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x100 with be=4'b1111, then be=4'b0010 data 0x00005500, read 0x100 -> next cycle read_data=0xDEAD55EF.
- Write 0x41,0x42,0x43 to CONSOLE_TX with console_ready=0, then ready=1 -> console_data 0x41,0x42,0x43 over three cycles, valid drops after; status reads 0x2 (empty).
- 16 pushes + 17th with ready=0 -> status=0x5 (full|overflow); write 0x4 to STATUS -> 0x1; full FIFO with simultaneous push and pop -> no overflow, count stays 16.
- Force counter to 0x0000_0000_FFFF_FFFF (or run to it), read CYCLE_LO then CYCLE_HI -> HI equals value sampled with LO (0), not post-carry 1.
- Read 0x4000_0000 -> read_data=0, unmapped_error=1 and stays 1; GPIO write 0x1234_5678 be=4'b1100 -> gpio_out=0x1234_0000.
- Assert reset mid-FIFO-drain with 5 bytes queued -> console_valid=0, gpio_out=0, read_data=0 immediately; RAM word 0x100 still 0xDEAD55EF after reset.

Source files
------------

// File: rtl/rv32i_package.sv
// Shared definitions for the rv32i data-memory responder: address regions and
// MMIO register offsets within the 64-byte MMIO window.
package rv32i_package;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_t;

    localparam logic [5:0] MMIO_CONSOLE_TX     = 6'h00;
    localparam logic [5:0] MMIO_CONSOLE_STATUS = 6'h04;
    localparam logic [5:0] MMIO_CYCLE_LO       = 6'h08;
    localparam logic [5:0] MMIO_CYCLE_HI       = 6'h0C;
    localparam logic [5:0] MMIO_GPIO           = 6'h10;

    localparam int STATUS_OVERFLOW_BIT = 2;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Single-clock FIFO with registered storage and count-based full/empty.
// A push while full is accepted only when a pop frees an entry in the same cycle.
module rv32i_sync_fifo
    import rv32i_package::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == DEPTH_COUNT);
    assign empty = (count_q == '0);
    // Head reads as zero when empty so the sink never sees stale storage.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/rv32i_data_responder.sv
// Data-memory responder for the rv32i core: word RAM with byte-enable writes and
// a registered read port, plus an MMIO window with console FIFO, cycle counter and GPIO.
module rv32i_data_responder
    import rv32i_package::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_write,
    input  logic        memory_read,
    input  logic [31:0] memory_address,
    input  logic [3:0]  memory_byteenable,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic [31:0] gpio_out,
    output logic        unmapped_error
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0] ram_q [RAM_WORDS];

    logic [31:0] read_data_q, read_data_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] gpio_q, gpio_d;
    logic        overflow_q, overflow_d;
    logic        error_q, error_d;

    region_t         region;
    logic [RAM_AW-1:0] ram_idx;
    logic [5:0]      mmio_off;
    logic [31:0]     ram_word;
    logic            ram_we;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic            unused_ok;

    // Accesses are whole words; the byte offset carries no information.
    assign unused_ok = &{1'b0, memory_address[1:0]};

    always_comb begin
        region = REGION_NONE;
        if (memory_address[31:RAM_AW+2] == '0) begin
            region = REGION_RAM;
        end else if (memory_address[31:6] == MMIO_BASE[31:6]) begin
            region = REGION_MMIO;
        end
    end

    assign ram_idx  = memory_address[RAM_AW+1:2];
    assign mmio_off = {memory_address[5:2], 2'b00};
    assign ram_word = ram_q[ram_idx];
    assign ram_we   = memory_write && (region == REGION_RAM);
    assign fifo_pop = console_valid && console_ready;

    always_comb begin
        read_data_d = read_data_q;
        cycle_d     = cycle_q + 64'd1;
        shadow_d    = shadow_q;
        gpio_d      = gpio_q;
        overflow_d  = overflow_q;
        error_d     = error_q;
        fifo_push   = 1'b0;

        if (memory_read) begin
            read_data_d = '0;
            if (region == REGION_RAM) begin
                read_data_d = ram_word;
            end else if (region == REGION_MMIO) begin
                case (mmio_off)
                    MMIO_CONSOLE_STATUS: read_data_d = {29'd0, overflow_q, fifo_empty, fifo_full};
                    MMIO_CYCLE_LO: begin
                        read_data_d = cycle_q[31:0];
                        shadow_d    = cycle_q[63:32];
                    end
                    MMIO_CYCLE_HI: read_data_d = shadow_q;
                    MMIO_GPIO:     read_data_d = gpio_q;
                    default:       read_data_d = '0;
                endcase
            end
        end

        if (memory_write && (region == REGION_MMIO)) begin
            case (mmio_off)
                MMIO_CONSOLE_TX: fifo_push = memory_byteenable[0];
                MMIO_CONSOLE_STATUS: begin
                    if (memory_byteenable[0] && memory_write_data[STATUS_OVERFLOW_BIT]) begin
                        overflow_d = 1'b0;
                    end
                end
                MMIO_GPIO: begin
                    for (int i = 0; i < 4; i++) begin
                        if (memory_byteenable[i]) begin
                            gpio_d[8*i +: 8] = memory_write_data[8*i +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end

        // A dropped byte wins over a same-cycle clear so the loss is never hidden.
        if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end

        if ((memory_read || memory_write) && (region == REGION_NONE)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
            cycle_q     <= '0;
            shadow_q    <= '0;
            gpio_q      <= '0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            cycle_q     <= cycle_d;
            shadow_q    <= shadow_d;
            gpio_q      <= gpio_d;
            overflow_q  <= overflow_d;
            error_q     <= error_d;
        end
    end

    // RAM contents survive reset; only the addressed word's enabled lanes change.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (memory_byteenable[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= memory_write_data[8*i +: 8];
                end
            end
        end
    end

    rv32i_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (memory_write_data[7:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign memory_read_data = read_data_q;
    assign console_valid    = !fifo_empty;
    assign console_data     = fifo_head;
    assign gpio_out         = gpio_q;
    assign unmapped_error   = error_q;

endmodule

// File: tb/tb_rv32i_data_responder.sv
// Directed bench for rv32i_data_responder: stimulus queues expected read words and
// console bytes; independent monitors pop and compare as the DUT presents them.
module tb_rv32i_data_responder;

    localparam logic [31:0] MMIO   = 32'h8000_0000;
    localparam logic [31:0] TX     = MMIO + 32'h00;
    localparam logic [31:0] STATUS = MMIO + 32'h04;
    localparam logic [31:0] LO     = MMIO + 32'h08;
    localparam logic [31:0] HI     = MMIO + 32'h0C;
    localparam logic [31:0] GPIO   = MMIO + 32'h10;

    logic        clk;
    logic        reset;
    logic        memory_write;
    logic        memory_read;
    logic [31:0] memory_address;
    logic [3:0]  memory_byteenable;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;
    logic [31:0] gpio_out;
    logic        unmapped_error;

    int total = 0;
    int bad   = 0;
    int tb_edges = 0;

    logic [31:0] exp_rd [$];
    string       exp_rd_name [$];
    logic [7:0]  exp_con [$];
    logic        rd_pend = 1'b0;

    rv32i_data_responder dut (
        .clk               (clk),
        .reset             (reset),
        .memory_write      (memory_write),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .memory_byteenable (memory_byteenable),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .console_valid     (console_valid),
        .console_data      (console_data),
        .console_ready     (console_ready),
        .gpio_out          (gpio_out),
        .unmapped_error    (unmapped_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; equals the counter value the next edge samples.
    always @(posedge clk) begin
        if (reset) tb_edges <= 0;
        else       tb_edges <= tb_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        memory_write      = 1'b1;
        memory_address    = addr;
        memory_write_data = data;
        memory_byteenable = be;
        tick();
        memory_write      = 1'b0;
        memory_byteenable = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] want, input string name);
        memory_read    = 1'b1;
        memory_address = addr;
        exp_rd.push_back(want);
        exp_rd_name.push_back(name);
        tick();
        memory_read = 1'b0;
    endtask

    // Read monitor: a read seen before an edge is checked at the following negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_underflow: got read with no expectation, required none");
                end else begin
                    check(exp_rd_name.pop_front(), memory_read_data, exp_rd.pop_front());
                end
            end
            rd_pend = memory_read && !reset;
        end
    end

    // Console monitor: each accepted byte is compared against the queued stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && console_valid && console_ready) begin
                if (exp_con.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL con_underflow: got byte %h, required none", console_data);
                end else begin
                    check("console_byte", {24'd0, console_data}, {24'd0, exp_con.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        memory_write = 1'b0;
        memory_read = 1'b0;
        memory_address = '0;
        memory_byteenable = '0;
        memory_write_data = '0;
        console_ready = 1'b0;
        #12;
        check("rst_read_data", memory_read_data, 32'h0);
        check("rst_console_valid", {31'd0, console_valid}, 32'h0);
        check("rst_console_data", {24'd0, console_data}, 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_unmapped", {31'd0, unmapped_error}, 32'h0);
        tick();
        reset = 1'b0;

        // Counter starts at zero and advances one per edge.
        rd(LO, tb_edges, "cycle_lo_start");
        tick(); tick(); tick();
        rd(LO, tb_edges, "cycle_lo_later");

        // RAM byte-enable writes and read-before-write.
        wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h100, 32'h0000_5500, 4'b0010);
        rd(32'h100, 32'hDEAD_55EF, "ram_be_merge");
        wr(32'h100, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h100, 32'hDEAD_55EF, "ram_be_zero");
        wr(32'h200, 32'h1111_1111, 4'b1111);
        memory_read = 1'b1;
        exp_rd.push_back(32'h1111_1111);
        exp_rd_name.push_back("ram_read_before_write");
        wr(32'h200, 32'h2222_2222, 4'b1111);
        memory_read = 1'b0;
        rd(32'h200, 32'h2222_2222, "ram_after_rbw");

        // Unused MMIO offsets and the TX register read as zero without error.
        rd(MMIO + 32'h20, 32'h0, "mmio_unused");
        rd(TX, 32'h0, "mmio_tx_read");
        check("no_error_in_map", {31'd0, unmapped_error}, 32'h0);

        // Console: three bytes queued with sink stalled, then drained.
        check("con_idle_valid", {31'd0, console_valid}, 32'h0);
        wr(TX, 32'h41, 4'b0001);
        check("con_valid_next", {31'd0, console_valid}, 32'h1);
        check("con_head", {24'd0, console_data}, 32'h41);
        wr(TX, 32'h42, 4'b0001);
        wr(TX, 32'h43, 4'b0001);
        exp_con.push_back(8'h41);
        exp_con.push_back(8'h42);
        exp_con.push_back(8'h43);
        rd(STATUS, 32'h0, "status_partial");
        check("con_stable", {24'd0, console_data}, 32'h41);
        console_ready = 1'b1;
        tick(); tick(); tick();
        console_ready = 1'b0;
        check("con_drained_valid", {31'd0, console_valid}, 32'h0);
        rd(STATUS, 32'h2, "status_empty");

        // Fill, overflow, clear, then push+pop while full.
        for (int i = 0; i < 16; i++) begin
            wr(TX, 32'h50 + i, 4'b0001);
            exp_con.push_back(8'(8'h50 + i));
        end
        wr(TX, 32'h60, 4'b0001);
        rd(STATUS, 32'h5, "status_full_ovf");
        wr(STATUS, 32'h4, 4'b0001);
        rd(STATUS, 32'h1, "status_ovf_cleared");
        console_ready = 1'b1;
        wr(TX, 32'h61, 4'b0001);
        console_ready = 1'b0;
        exp_con.push_back(8'h61);
        rd(STATUS, 32'h1, "status_full_pushpop");
        console_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        console_ready = 1'b0;
        check("con_full_drained", {31'd0, console_valid}, 32'h0);
        rd(STATUS, 32'h2, "status_empty_again");

        // Coherent 64-bit read across a low-word carry.
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        rd(LO, 32'hFFFF_FFFF, "cycle_lo_pre_carry");
        force dut.cycle_q = 64'h0000_0001_0000_0000;
        rd(HI, 32'h0, "cycle_hi_shadow");
        release dut.cycle_q;

        // Unmapped access and GPIO lane writes.
        rd(32'h4000_0000, 32'h0, "unmapped_read");
        check("unmapped_set", {31'd0, unmapped_error}, 32'h1);
        tick(); tick();
        check("unmapped_sticky", {31'd0, unmapped_error}, 32'h1);
        wr(GPIO, 32'h1234_5678, 4'b1100);
        check("gpio_lanes", gpio_out, 32'h1234_0000);
        rd(GPIO, 32'h1234_0000, "gpio_readback");

        // Asynchronous reset in the middle of a console drain.
        rd(32'h100, 32'hDEAD_55EF, "ram_before_reset");
        for (int i = 0; i < 5; i++) wr(TX, 32'h70 + i, 4'b0001);
        exp_con.push_back(8'h70);
        exp_con.push_back(8'h71);
        console_ready = 1'b1;
        tick(); tick();
        #1 reset = 1'b1;
        #1;
        check("arst_console_valid", {31'd0, console_valid}, 32'h0);
        check("arst_console_data", {24'd0, console_data}, 32'h0);
        check("arst_gpio", gpio_out, 32'h0);
        check("arst_read_data", memory_read_data, 32'h0);
        check("arst_unmapped", {31'd0, unmapped_error}, 32'h0);
        exp_con.delete();
        console_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        rd(32'h100, 32'hDEAD_55EF, "ram_kept_after_reset");
        rd(STATUS, 32'h2, "status_after_reset");

        tick(); tick(); tick();
        check("rd_queue_empty", exp_rd.size(), 32'h0);
        check("con_queue_empty", exp_con.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
